// File: rtl/synth_pkg.sv
// Shared synth types and helpers: mixer FSM states, default widths, the saturator
// also used by the waveform generators, and the clamped envelope step.
package synth_pkg;

   localparam int SAMPLE_W_DEF = 24;
   localparam int VOL_W_DEF    = 8;

   typedef enum logic [2:0] {IDLE, LATCH, ACCUM, SCALE, OUT} mix_state_t;

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] in, input int width);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (in > hi) return hi;
      if (in < lo) return lo;
      return in;
   endfunction

   // One frame of linear attack/release, pinned at 0 and 2^width-1 so it never wraps
   function automatic logic [31:0] env_step(input logic [31:0] env, input logic gate,
                                            input logic [31:0] atk, input logic [31:0] rel,
                                            input int width);
      logic [32:0] sum;
      logic [31:0] top;
      top = (32'd1 << width) - 32'd1;
      if (gate) begin
         sum = {1'b0, env} + {1'b0, atk};
         return (sum > {1'b0, top}) ? top : sum[31:0];
      end
      return (rel >= env) ? 32'd0 : env - rel;
   endfunction

endpackage

// File: rtl/poly_voice_mixer_if.sv
// Voice/control bundle between the waveform side (master) and poly_voice_mixer (slave).
interface poly_voice_mixer_if #(
   parameter int NUM_VOICES = 8,
   parameter int SAMPLE_W   = 24,
   parameter int VOL_W      = 8
);
   logic                                 sample_tick;
   logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  voice_sample;
   logic [NUM_VOICES-1:0][VOL_W-1:0]     voice_vol;
   logic [NUM_VOICES-1:0]                voice_gate;
   logic [VOL_W-1:0]                     attack_step;
   logic [VOL_W-1:0]                     release_step;
   logic [VOL_W-1:0]                     master_vol;
   logic [SAMPLE_W-1:0]                  mixed_sample;
   logic                                 mixed_valid;
   logic                                 clip;
   logic                                 busy;
   logic [7:0]                           drop_cnt;
   logic [VOL_W-1:0]                     peak_level;

   modport master (
      output sample_tick, voice_sample, voice_vol, voice_gate,
             attack_step, release_step, master_vol,
      input  mixed_sample, mixed_valid, clip, busy, drop_cnt, peak_level
   );

   modport slave (
      input  sample_tick, voice_sample, voice_vol, voice_gate,
             attack_step, release_step, master_vol,
      output mixed_sample, mixed_valid, clip, busy, drop_cnt, peak_level
   );
endinterface

// File: rtl/env_ramp.sv
// Single shared envelope step unit; the mixer feeds it one voice per ACCUM cycle.
module env_ramp
   import synth_pkg::*;
#(
   parameter int VOL_W = VOL_W_DEF
) (
   input  logic [VOL_W-1:0] env,
   input  logic             gate,
   input  logic [VOL_W-1:0] atk,
   input  logic [VOL_W-1:0] rel,
   output logic [VOL_W-1:0] env_nxt
);
   assign env_nxt = VOL_W'(env_step(32'(env), gate, 32'(atk), 32'(rel), VOL_W));
endmodule

// File: rtl/poly_voice_mixer.sv
// N-voice sequential mixer: per-voice envelope and volume, master scale, saturation.
// Optional peak meter enabled by defining MIXER_PEAK_METER_EN.
module poly_voice_mixer
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int VOL_W      = VOL_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   poly_voice_mixer_if.slave mix
);
   localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(NUM_VOICES) + 1;
   localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int PROD_W = ACC_W + VOL_W + 1;
   localparam int SCL_W  = PROD_W - 2 * VOL_W;

   mix_state_t state, state_nxt;
   logic       busy;

   logic [IDX_W-1:0]                    idx;
   logic [NUM_VOICES-1:0][SAMPLE_W-1:0] smp_l;
   logic [NUM_VOICES-1:0][VOL_W-1:0]    vol_l;
   logic [NUM_VOICES-1:0]               gate_l;
   logic [VOL_W-1:0]                    atk_l, rel_l, mvol_l;
   logic [NUM_VOICES-1:0][VOL_W-1:0]    env;

   logic signed [ACC_W-1:0]  acc;
   logic signed [SCL_W-1:0]  scaled;
   logic [SAMPLE_W-1:0]      mixed_sample;
   logic                     mixed_valid, clip;
   logic [7:0]               drop_cnt;

   logic [VOL_W-1:0]              env_nxt, gain;
   logic [2*VOL_W-1:0]            gain_full;
   logic signed [SAMPLE_W+VOL_W:0] term;
   logic signed [PROD_W-1:0]      prod;
   logic signed [63:0]            sat;
   logic                          last_voice;

   env_ramp #(.VOL_W(VOL_W)) u_env_ramp (
      .env     (env[idx]),
      .gate    (gate_l[idx]),
      .atk     (atk_l),
      .rel     (rel_l),
      .env_nxt (env_nxt)
   );

   assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));
   assign gain_full  = {{VOL_W{1'b0}}, vol_l[idx]} * {{VOL_W{1'b0}}, env_nxt};
   assign gain       = VOL_W'(gain_full >> VOL_W);
   assign term       = $signed(smp_l[idx]) * $signed({1'b0, gain});
   assign prod       = acc * $signed({1'b0, mvol_l});
   assign sat        = sat_signed(64'(scaled), SAMPLE_W);

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      unique case (state)
         IDLE:  begin
            busy = 1'b0;
            if (mix.sample_tick) state_nxt = LATCH;
         end
         LATCH: state_nxt = ACCUM;
         ACCUM: if (last_voice) state_nxt = SCALE;
         SCALE: state_nxt = OUT;
         OUT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         smp_l        <= '0;
         vol_l        <= '0;
         gate_l       <= '0;
         atk_l        <= '0;
         rel_l        <= '0;
         mvol_l       <= '0;
         env          <= '0;
         acc          <= '0;
         scaled       <= '0;
         mixed_sample <= '0;
         mixed_valid  <= 1'b0;
         clip         <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         mixed_valid <= 1'b0;
         clip        <= 1'b0;
         // Ticks landing mid-frame (OUT included) are counted, never queued
         if (mix.sample_tick && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         unique case (state)
            IDLE: idx <= '0;
            LATCH: begin
               smp_l  <= mix.voice_sample;
               vol_l  <= mix.voice_vol;
               gate_l <= mix.voice_gate;
               atk_l  <= mix.attack_step;
               rel_l  <= mix.release_step;
               mvol_l <= mix.master_vol;
               acc    <= '0;
               idx    <= '0;
            end
            ACCUM: begin
               env[idx] <= env_nxt;
               acc      <= acc + ACC_W'(term);
               idx      <= idx + 1'b1;
            end
            SCALE: scaled <= SCL_W'(prod >>> (2 * VOL_W));
            OUT: begin
               mixed_sample <= SAMPLE_W'(sat);
               mixed_valid  <= 1'b1;
               clip         <= (sat != 64'(scaled));
            end
            default: ;
         endcase
      end
   end

   assign mix.mixed_sample = mixed_sample;
   assign mix.mixed_valid  = mixed_valid;
   assign mix.clip         = clip;
   assign mix.busy         = busy;
   assign mix.drop_cnt     = drop_cnt;

`ifdef MIXER_PEAK_METER_EN
   logic [SAMPLE_W-1:0] neg;
   logic [SAMPLE_W-2:0] mag;
   logic [VOL_W-1:0]    m, peak;

   // |x| clamped to full-scale positive so the most negative sample still reads as peak
   always_comb begin
      neg = -mixed_sample;
      if (!mixed_sample[SAMPLE_W-1]) mag = mixed_sample[SAMPLE_W-2:0];
      else if (neg[SAMPLE_W-1])      mag = '1;
      else                           mag = neg[SAMPLE_W-2:0];
      m = VOL_W'(mag >> (SAMPLE_W - 1 - VOL_W));
   end

   always_ff @(posedge clk) begin
      if (!reset_n)         peak <= '0;
      else if (mixed_valid) peak <= (m > peak) ? m : ((peak == '0) ? '0 : peak - 1'b1);
   end

   assign mix.peak_level = peak;
`else
   assign mix.peak_level = '0;
`endif

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer: 4-voice vector table plus multi-cycle corner sequences,
// and an 8-voice instance for latency and peak meter.
module tb_poly_voice_mixer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #10 clk = ~clk;

   poly_voice_mixer_if #(.NUM_VOICES(4), .SAMPLE_W(24), .VOL_W(8)) if4 ();
   poly_voice_mixer_if #(.NUM_VOICES(8), .SAMPLE_W(24), .VOL_W(8)) if8 ();

   poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_W(24), .VOL_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .mix(if4.slave));
   poly_voice_mixer #(.NUM_VOICES(8), .SAMPLE_W(24), .VOL_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .mix(if8.slave));

   typedef struct {
      logic [3:0][23:0] smp;
      logic [3:0][7:0]  vol;
      logic [3:0]       gate;
      logic [7:0]       atk, rel, mv;
      logic [23:0]      exp_s;
      logic             exp_c;
   } vec_t;

   localparam logic [3:0][23:0] S_ONE  = {24'h0, 24'h0, 24'h0, 24'h100000};
   localparam logic [3:0][23:0] S_PMAX = {24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
   localparam logic [3:0][23:0] S_NMAX = {24'h800000, 24'h800000, 24'h800000, 24'h800000};
   localparam logic [3:0][23:0] S_MIX  = {24'h0, 24'h200000, 24'hF00000, 24'h100000};
   localparam logic [3:0][23:0] S_M1   = {24'h0, 24'h0, 24'h0, 24'hFFFFFF};
   localparam logic [3:0][7:0]  V_ALL  = {8'd255, 8'd255, 8'd255, 8'd255};
   localparam logic [3:0][7:0]  V_0    = {8'd0, 8'd0, 8'd0, 8'd255};
   localparam logic [3:0][7:0]  V_HALF = {8'd0, 8'd0, 8'd0, 8'd128};

   vec_t vt[16];
   int total = 0;
   int bad = 0;

   function automatic vec_t mk(logic [3:0][23:0] s, logic [3:0][7:0] v, logic [3:0] g,
                               logic [7:0] a, logic [7:0] r, logic [7:0] m,
                               logic [23:0] es, logic ec);
      vec_t x;
      x.smp = s; x.vol = v; x.gate = g; x.atk = a; x.rel = r; x.mv = m;
      x.exp_s = es; x.exp_c = ec;
      return x;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic apply4(input vec_t x);
      if4.voice_sample = x.smp;
      if4.voice_vol    = x.vol;
      if4.voice_gate   = x.gate;
      if4.attack_step  = x.atk;
      if4.release_step = x.rel;
      if4.master_vol   = x.mv;
   endtask

   // One 4-voice frame: tick, bounded wait for mixed_valid, check latency/data/pulse width
   task automatic frame4(input string nm, input logic [23:0] es, input logic ec);
      int n;
      @(negedge clk) if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      check({nm, " busy"}, 64'(if4.busy), 64'd1);
      n = 0;
      while (!if4.mixed_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({nm, " latency"}, 64'(n), 64'd7);
      check({nm, " sample"}, 64'(if4.mixed_sample), 64'(es));
      check({nm, " clip"}, 64'(if4.clip), 64'(ec));
      @(negedge clk);
      check({nm, " pulse"}, 64'(if4.mixed_valid), 64'd0);
   endtask

   initial begin
      int pulses, first;
      logic [7:0] exp_pk;

      vt[0]  = mk(S_ONE,  V_0,    4'b0001, 8'd255, 8'd0,  8'd255, 24'h0FD020, 1'b0);
      vt[1]  = mk(S_ONE,  V_0,    4'b0001, 8'd255, 8'd0,  8'd255, 24'h0FD020, 1'b0);
      vt[2]  = mk(S_PMAX, V_ALL,  4'b1111, 8'd255, 8'd0,  8'd255, 24'h7FFFFF, 1'b1);
      vt[3]  = mk(S_NMAX, V_ALL,  4'b1111, 8'd255, 8'd0,  8'd255, 24'h800000, 1'b1);
      vt[4]  = mk(S_PMAX, V_ALL,  4'b1111, 8'd255, 8'd0,  8'd0,   24'h000000, 1'b0);
      vt[5]  = mk(S_MIX,  V_ALL,  4'b1111, 8'd255, 8'd0,  8'd128, 24'h0FE000, 1'b0);
      vt[6]  = mk(S_M1,   V_0,    4'b1111, 8'd255, 8'd0,  8'd255, 24'hFFFFFF, 1'b0);
      vt[7]  = mk(S_ONE,  V_HALF, 4'b1111, 8'd255, 8'd0,  8'd255, 24'h07E810, 1'b0);
      vt[8]  = mk(S_ONE,  V_0,    4'b0000, 8'd255, 8'd64, 8'd255, 24'h0BD420, 1'b0);
      vt[9]  = mk(S_ONE,  V_0,    4'b0000, 8'd255, 8'd64, 8'd255, 24'h07D820, 1'b0);
      vt[10] = mk(S_ONE,  V_0,    4'b0000, 8'd255, 8'd64, 8'd255, 24'h03DC20, 1'b0);
      vt[11] = mk(S_ONE,  V_0,    4'b0000, 8'd255, 8'd64, 8'd255, 24'h000000, 1'b0);
      vt[12] = mk(S_ONE,  V_0,    4'b0000, 8'd255, 8'd64, 8'd255, 24'h000000, 1'b0);
      vt[13] = mk(S_ONE,  V_0,    4'b0001, 8'd100, 8'd64, 8'd255, 24'h0629D0, 1'b0);
      vt[14] = mk(S_ONE,  V_0,    4'b0001, 8'd100, 8'd64, 8'd255, 24'h0C6390, 1'b0);
      vt[15] = mk(S_ONE,  V_0,    4'b0001, 8'd100, 8'd64, 8'd255, 24'h0FD020, 1'b0);

      if4.sample_tick = 1'b0;
      apply4(vt[0]);
      if8.sample_tick = 1'b0;
      if8.voice_sample = '0; if8.voice_sample[0] = 24'h100000;
      if8.voice_vol = '0;    if8.voice_vol[0] = 8'd255;
      if8.voice_gate = 8'h01;
      if8.attack_step = 8'd255; if8.release_step = 8'd0; if8.master_vol = 8'd255;

      repeat (3) @(negedge clk);
      check("rst sample", 64'(if4.mixed_sample), 64'd0);
      check("rst valid", 64'(if4.mixed_valid), 64'd0);
      check("rst clip", 64'(if4.clip), 64'd0);
      check("rst busy", 64'(if4.busy), 64'd0);
      check("rst drop", 64'(if4.drop_cnt), 64'd0);
      check("rst peak", 64'(if8.peak_level), 64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk) apply4(vt[i]);
         frame4($sformatf("vec%0d", i), vt[i].exp_s, vt[i].exp_c);
      end

      // Second tick two cycles after the first is dropped
      @(negedge clk) if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      @(negedge clk) if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      pulses = 0; first = -1;
      for (int k = 3; k <= 20; k++) begin
         @(negedge clk);
         if (if4.mixed_valid) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("drop pulses", 64'(pulses), 64'd1);
      check("drop at", 64'(first), 64'd7);
      check("drop cnt", 64'(if4.drop_cnt), 64'd1);

      // Tick during OUT is dropped too and does not start a frame
      @(negedge clk) if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      repeat (6) @(negedge clk);
      check("out busy", 64'(if4.busy), 64'd1);
      if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      check("out valid", 64'(if4.mixed_valid), 64'd1);
      check("out drop", 64'(if4.drop_cnt), 64'd2);
      @(negedge clk);
      check("out idle", 64'(if4.busy), 64'd0);

      // Reset during ACCUM idx 2
      @(negedge clk) if4.sample_tick = 1'b1;
      @(negedge clk) if4.sample_tick = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort busy", 64'(if4.busy), 64'd0);
      check("abort valid", 64'(if4.mixed_valid), 64'd0);
      check("abort sample", 64'(if4.mixed_sample), 64'd0);
      check("abort drop", 64'(if4.drop_cnt), 64'd0);
      reset_n = 1'b1;
      @(negedge clk) apply4(mk(S_ONE, V_0, 4'b0000, 8'd255, 8'd0, 8'd255, 24'h0, 1'b0));
      frame4("env cleared", 24'h000000, 1'b0);

      // Tick coincident with reset is lost
      @(negedge clk) begin reset_n = 1'b0; if4.sample_tick = 1'b1; end
      @(negedge clk) begin reset_n = 1'b1; if4.sample_tick = 1'b0; end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (if4.mixed_valid || if4.busy) pulses++;
      end
      check("rst tick lost", 64'(pulses), 64'd0);
      check("rst tick drop", 64'(if4.drop_cnt), 64'd0);

      // Continuous tick saturates drop counter
      @(negedge clk) if4.sample_tick = 1'b1;
      repeat (320) @(negedge clk);
      if4.sample_tick = 1'b0;
      repeat (12) @(negedge clk);
      check("drop sat", 64'(if4.drop_cnt), 64'd255);

      // 8-voice latency and peak meter
      @(negedge clk) if8.sample_tick = 1'b1;
      @(negedge clk) if8.sample_tick = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k <= 10 && if8.mixed_valid) pulses++;
         if (k == 11) begin
            check("n8 valid", 64'(if8.mixed_valid), 64'd1);
            check("n8 sample", 64'(if8.mixed_sample), 64'h0FD020);
         end
         if (k == 12) check("n8 pulse", 64'(if8.mixed_valid), 64'd0);
      end
      check("n8 early", 64'(pulses), 64'd0);
`ifdef MIXER_PEAK_METER_EN
      exp_pk = 8'd31;
`else
      exp_pk = 8'd0;
`endif
      check("peak rise", 64'(if8.peak_level), 64'(exp_pk));
      if8.voice_vol[0] = 8'd0;
      @(negedge clk) if8.sample_tick = 1'b1;
      @(negedge clk) if8.sample_tick = 1'b0;
      repeat (13) @(negedge clk);
      check("n8 silent", 64'(if8.mixed_sample), 64'd0);
`ifdef MIXER_PEAK_METER_EN
      exp_pk = 8'd30;
`else
      exp_pk = 8'd0;
`endif
      check("peak decay", 64'(if8.peak_level), 64'(exp_pk));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
